// File: rtl/oc8051_rr_busarbiter.sv
// Round-robin arbiter sharing one external memory port among four oc8051 masters.
// Registered grant, per-port ack/err routing, and a watchdog that aborts hung transfers.
module oc8051_rr_busarbiter #(
    parameter int TIMEOUT_CYC = 64,
    parameter int ERRCNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req_stb,
    input  logic [3:0]          req_wr,
    input  logic [63:0]         req_addr,
    input  logic [31:0]         req_data_in,
    input  logic [3:0]          req_priv,
    output logic [3:0]          req_ack,
    output logic [3:0]          req_err,
    output logic [7:0]          req_data_out,
    output logic                stb,
    output logic                wr,
    output logic [15:0]         addr,
    output logic [7:0]          data_in,
    output logic                priv_lvl,
    input  logic                ack,
    input  logic [7:0]          data_out,
    output logic                grant_vld,
    output logic [1:0]          grant_id,
    output logic [ERRCNT_W-1:0] tmo_count
);
    localparam int NPORTS = 4;
    localparam int WDOG_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

    state_t                state_reg, state_next;
    logic [1:0]            last_grant_reg, last_grant_next;
    logic [1:0]            grant_id_reg, grant_id_next;
    logic [WDOG_W-1:0]     wdog_reg, wdog_next;
    logic [ERRCNT_W-1:0]   tmo_count_reg, tmo_count_next;
    logic [NPORTS-1:0]     skip_mask_reg, skip_mask_next;

    logic [15:0]           port_addr [NPORTS];
    logic [7:0]            port_data [NPORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            assign port_addr[gi] = req_addr[16*gi +: 16];
            assign port_data[gi] = req_data_in[8*gi +: 8];
        end
    endgenerate

    logic [NPORTS-1:0] eligible;
    logic [1:0]        winner;
    logic [NPORTS-1:0] gnt_onehot;
    logic              gnt_stb;
    logic              busy;
    logic              timeout_hit;

    assign busy        = (state_reg == BUSY);
    assign gnt_onehot  = 4'b0001 << grant_id_reg;
    assign gnt_stb     = req_stb[grant_id_reg];
    assign timeout_hit = (wdog_reg == WDOG_W'(TIMEOUT_CYC - 1));
    assign eligible    = req_stb & ~skip_mask_reg;

    // Scan from farthest to nearest so the port right after last_grant wins.
    always_comb begin
        winner = last_grant_reg;
        for (int k = NPORTS; k >= 1; k--) begin
            if (eligible[last_grant_reg + 2'(k)]) begin
                winner = last_grant_reg + 2'(k);
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_id_next   = grant_id_reg;
        wdog_next       = wdog_reg;
        tmo_count_next  = tmo_count_reg;
        skip_mask_next  = skip_mask_reg;
        case (state_reg)
            IDLE: begin
                skip_mask_next = '0;
                if (|eligible) begin
                    grant_id_next = winner;
                    wdog_next     = '0;
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                wdog_next = wdog_reg + 1'b1;
                if (ack) begin
                    state_next      = IDLE;
                    last_grant_next = grant_id_reg;
                    skip_mask_next  = gnt_onehot;
                end else if (!gnt_stb) begin
                    state_next      = IDLE;
                    last_grant_next = grant_id_reg;
                end else if (timeout_hit) begin
                    state_next = RECOVER;
                    if (tmo_count_reg != '1) begin
                        tmo_count_next = tmo_count_reg + 1'b1;
                    end
                end
            end
            RECOVER: begin
                state_next      = IDLE;
                last_grant_next = grant_id_reg;
                skip_mask_next  = gnt_onehot;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 2'd3;
            grant_id_reg   <= 2'd0;
            wdog_reg       <= '0;
            tmo_count_reg  <= '0;
            skip_mask_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_id_reg   <= grant_id_next;
            wdog_reg       <= wdog_next;
            tmo_count_reg  <= tmo_count_next;
            skip_mask_reg  <= skip_mask_next;
        end
    end

    // Memory side follows the granted port only while BUSY; acks outside BUSY are dropped.
    always_comb begin
        stb      = busy & gnt_stb;
        wr       = busy & req_wr[grant_id_reg];
        priv_lvl = busy & req_priv[grant_id_reg];
        addr     = busy ? port_addr[grant_id_reg] : 16'h0000;
        data_in  = busy ? port_data[grant_id_reg] : 8'h00;
        req_ack  = (busy && ack) ? gnt_onehot : 4'b0000;
        req_err  = (busy && !ack && gnt_stb && timeout_hit) ? gnt_onehot : 4'b0000;
    end

    assign req_data_out = data_out;
    assign grant_vld    = busy;
    assign grant_id     = grant_id_reg;
    assign tmo_count    = tmo_count_reg;

endmodule

// File: tb/tb_oc8051_rr_busarbiter.sv
// Scoreboarded bench for the round-robin bus arbiter: directed scenarios plus random traffic,
// checked against a transaction-level reference model of the arbitration rules.
module tb_oc8051_rr_busarbiter;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_stb, req_wr, req_priv;
    logic [63:0] req_addr;
    logic [31:0] req_data_in;
    logic        ack;
    logic [7:0]  data_out;
    logic [3:0]  req_ack, req_err;
    logic [7:0]  req_data_out;
    logic        stb, wr, priv_lvl, grant_vld;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic [1:0]  grant_id;
    logic [7:0]  tmo_count;

    oc8051_rr_busarbiter #(.TIMEOUT_CYC(T), .ERRCNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_stb(req_stb), .req_wr(req_wr), .req_addr(req_addr),
        .req_data_in(req_data_in), .req_priv(req_priv), .req_ack(req_ack), .req_err(req_err),
        .req_data_out(req_data_out), .stb(stb), .wr(wr), .addr(addr), .data_in(data_in),
        .priv_lvl(priv_lvl), .ack(ack), .data_out(data_out), .grant_vld(grant_vld),
        .grant_id(grant_id), .tmo_count(tmo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] bus;
        logic [3:0]  ackv;
        logic [3:0]  err;
        logic [2:0]  grant;
        logic [7:0]  tmo;
        logic [7:0]  rdata;
    } exp_t;

    exp_t exp_q[$];
    int   exp_grant_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ack_mode = 0;

    // Reference model: 0 idle, 1 busy, 2 recover; m_wd = BUSY cycles already elapsed.
    int       m_st, m_last, m_gid, m_wd, m_tmo;
    bit [3:0] m_skip;

    function void model_reset();
        m_st = 0; m_last = 3; m_gid = 0; m_wd = 0; m_tmo = 0; m_skip = 4'b0000;
    endfunction

    function void model_step();
        bit [3:0] elig;
        bit       found;
        int       p;
        if (rst) begin
            model_reset();
            return;
        end
        case (m_st)
            0: begin
                elig   = req_stb & ~m_skip;
                m_skip = 4'b0000;
                found  = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    p = (m_last + k) % 4;
                    if (!found && elig[p]) begin
                        found = 1'b1; m_gid = p; m_st = 1; m_wd = 0;
                    end
                end
            end
            1: begin
                if (ack) begin
                    m_st = 0; m_last = m_gid; m_skip = 4'b0001 << m_gid;
                end else if (!req_stb[m_gid]) begin
                    m_st = 0; m_last = m_gid;
                end else if (m_wd == T - 1) begin
                    m_st = 2;
                    if (m_tmo < 255) m_tmo++;
                end else begin
                    m_wd++;
                end
            end
            default: begin
                m_st = 0; m_last = m_gid; m_skip = 4'b0001 << m_gid;
            end
        endcase
    endfunction

    function exp_t model_out();
        exp_t e;
        bit   busy;
        busy    = (m_st == 1);
        e.bus   = busy ? {req_stb[m_gid], req_wr[m_gid], req_priv[m_gid],
                          req_data_in[8*m_gid +: 8], req_addr[16*m_gid +: 16]} : 27'd0;
        e.ackv  = (busy && ack) ? (4'b0001 << m_gid) : 4'b0000;
        e.err   = (busy && !ack && req_stb[m_gid] && m_wd == T - 1) ? (4'b0001 << m_gid) : 4'b0000;
        e.grant = {busy, 2'(m_gid)};
        e.tmo   = 8'(m_tmo);
        e.rdata = data_out;
        return e;
    endfunction

    // One clock of stimulus: pick ack from the memory policy, record the expectation, advance.
    task automatic apply();
        case (ack_mode)
            0: ack = 1'b0;
            1: ack = (m_st == 1 && m_wd == 1);
            2: ack = (m_st == 1 && m_wd == T - 1);
            default: ack = ($urandom_range(0, 3) == 0);
        endcase
        exp_q.push_back(model_out());
        @(posedge clk);
        model_step();
        #1;
        req_wr      = 4'($urandom_range(0, 15));
        req_priv    = 4'($urandom_range(0, 15));
        req_addr    = {$urandom, $urandom};
        req_data_in = $urandom;
        data_out    = 8'($urandom_range(0, 255));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) apply();
    endtask

    task automatic do_reset();
        rst = 1'b1; req_stb = 4'b0000;
        run(2);
        rst = 1'b0;
    endtask

    function void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    logic prev_vld = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mem_bus", {5'd0, stb, wr, priv_lvl, data_in, addr}, {5'd0, e.bus});
            chk("req_ack", {28'd0, req_ack}, {28'd0, e.ackv});
            chk("req_err", {28'd0, req_err}, {28'd0, e.err});
            chk("grant", {29'd0, grant_vld, grant_id}, {29'd0, e.grant});
            chk("tmo_count", {24'd0, tmo_count}, {24'd0, e.tmo});
            chk("rdata", {24'd0, req_data_out}, {24'd0, e.rdata});
            if (req_ack != 0 || req_err != 0)
                $display("txn t=%0t ack=%b err=%b grant=%0d addr=%h tmo=%0d",
                         $time, req_ack, req_err, grant_id, addr, tmo_count);
        end
        if (grant_vld === 1'b1 && !prev_vld && exp_grant_q.size() > 0)
            chk("grant_order", {30'd0, grant_id}, 32'(exp_grant_q.pop_front()));
        prev_vld = (grant_vld === 1'b1);
    end

    initial begin
        rst = 1'b1; req_stb = 4'b0000; req_wr = 4'b0000; req_priv = 4'b0000;
        req_addr = '0; req_data_in = '0; ack = 1'b0; data_out = 8'h00;
        @(posedge clk);
        model_reset();
        #1;
        do_reset();

        // Single request from port 0, memory acks on the second BUSY cycle.
        ack_mode = 1; req_stb = 4'b0001;
        exp_grant_q.push_back(0);
        apply();
        req_addr[15:0] = 16'h1234;
        run(5);
        req_stb = 4'b0000;
        run(2);

        // All four ports requesting continuously: strict rotation.
        do_reset();
        foreach (exp_grant_q[i]) exp_grant_q.delete(i);
        for (int i = 0; i < 8; i++) exp_grant_q.push_back(i % 4);
        req_stb = 4'b1111;
        run(40);

        // Port 2 lingers after its ack while port 3 waits.
        do_reset();
        exp_grant_q.push_back(2); exp_grant_q.push_back(3); exp_grant_q.push_back(2);
        req_stb = 4'b1100;
        run(10);

        // Port 1 never acked: timeout, recover, then port 0 gets the bus.
        do_reset();
        ack_mode = 0; req_stb = 4'b0010;
        exp_grant_q.push_back(1); exp_grant_q.push_back(0);
        run(2);
        req_stb = 4'b0011;
        run(16);

        // Ack arrives on the timeout cycle: ack wins.
        do_reset();
        ack_mode = 2; req_stb = 4'b0100;
        run(12);

        // Reset mid-transaction with port 3, then port 0 wins first.
        do_reset();
        ack_mode = 0; req_stb = 4'b1000;
        run(4);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        exp_grant_q.push_back(0);
        ack_mode = 1; req_stb = 4'b1111;
        run(6);

        // Random traffic with sticky requests and varying memory behaviour.
        req_stb = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            if (c % 25 == 0) ack_mode = $urandom_range(0, 3);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) req_stb[b] = ~req_stb[b];
            rst = ($urandom_range(0, 299) == 0);
            apply();
        end
        rst = 1'b0;
        @(negedge clk);
        #1;

        n_vec++;
        if (exp_grant_q.size() != 0) begin
            n_err++;
            $display("FAIL grant_order_pending: got %0d outstanding expected 0", exp_grant_q.size());
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_pending: got %0d outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
